// File: rtl/temp_bcd_display.sv
// Signed whole-degree Celsius to sign + four BCD digits, optional Fahrenheit, 2-cycle pipeline.
// Optional leading-zero blanking (digit code 4'hF) when TDISPLAY_BLANK_EN is defined.
module temp_bcd_display #(
  parameter int unsigned TW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] tc,
  input  logic          c_f,
  output logic [3:0]    thousands,
  output logic [3:0]    hundreds,
  output logic [3:0]    tens,
  output logic [3:0]    ones,
  output logic          sign
);

  localparam int unsigned IW = 17;
  localparam int unsigned MW = 13;

  logic signed [IW-1:0] tc_ext;
  logic signed [IW-1:0] f5;
  logic        [IW-1:0] abs_c;
  logic        [IW-1:0] abs_f;
  logic        [IW-1:0] div_f;
  logic        [MW-1:0] mag_d, mag_q;
  logic                 neg_d, neg_q;
  logic        [15:0]   bcd;
  logic        [3:0]    th_d, hu_d, te_d, on_d;
  logic        [3:0]    th_q, hu_q, te_q, on_q;
  logic                 sign_q;

  // Stage 1: unit conversion and magnitude/sign extraction
  always_comb begin
    tc_ext = signed'({{(IW-TW){tc[TW-1]}}, tc});
    f5     = signed'(IW'(9)) * tc_ext + signed'(IW'(160));
    abs_c  = tc_ext[IW-1] ? IW'(-tc_ext) : IW'(tc_ext);
    abs_f  = f5[IW-1] ? IW'(-f5) : IW'(f5);
    div_f  = (abs_f + IW'(2)) / IW'(5);
    if (c_f) begin
      mag_d = MW'(div_f);
      neg_d = f5[IW-1];
    end else begin
      mag_d = MW'(abs_c);
      neg_d = tc[TW-1];
    end
    if (mag_d == '0) neg_d = 1'b0;
  end

  // Stage 2: shift-add-3 binary to BCD
  always_comb begin
    bcd = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], mag_q[i]};
    end
    th_d = bcd[15:12];
    hu_d = bcd[11:8];
    te_d = bcd[7:4];
    on_d = bcd[3:0];
`ifdef TDISPLAY_BLANK_EN
    // Blank a digit only while every more-significant digit is also blank
    if (th_d == 4'd0) begin
      th_d = 4'hF;
      if (hu_d == 4'd0) begin
        hu_d = 4'hF;
        if (te_d == 4'd0) te_d = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      th_q   <= 4'd0;
      hu_q   <= 4'd0;
      te_q   <= 4'd0;
      on_q   <= 4'd0;
      sign_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      th_q   <= th_d;
      hu_q   <= hu_d;
      te_q   <= te_d;
      on_q   <= on_d;
      sign_q <= neg_q;
    end
  end

  assign thousands = th_q;
  assign hundreds  = hu_q;
  assign tens      = te_q;
  assign ones      = on_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_temp_bcd_display.sv
// Directed bench for temp_bcd_display: reset, Celsius/Fahrenheit conversion, rounding, pipelining.
module tb_temp_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] tc;
  logic        c_f;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        sign;

  int checks = 0;
  int errors = 0;

  temp_bcd_display #(.TW(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .tc        (tc),
    .c_f       (c_f),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic s, input logic [15:0] d);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {sign, thousands, hundreds, tens, ones};
    exp = {s, d};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sign=%b digits=%h expected sign=%b digits=%h",
             tag, obs[16], obs[15:0], exp[16], exp[15:0]);
    end
  endtask

  // Drive one sample at a falling edge and check it two rising edges later
  task automatic apply(input string tag, input int t, input logic cf,
                       input logic s, input logic [15:0] d);
    @(negedge clk);
    tc  = 13'(t);
    c_f = cf;
    @(negedge clk);
    @(negedge clk);
    check(tag, s, d);
  endtask

  int          pv_tc [3] = '{-5, 25, 100};
  logic        pv_cf [3] = '{1'b0, 1'b0, 1'b1};
  logic        pe_s  [3] = '{1'b1, 1'b0, 1'b0};
  logic [15:0] pe_d  [3] = '{16'h0005, 16'h0025, 16'h0212};

  initial begin
    rst = 1'b1;
    tc  = 13'd123;
    c_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset", 1'b0, 16'h0000);

    @(negedge clk);
    rst = 1'b0;
    tc  = 13'(-5);
    @(negedge clk);
    @(negedge clk);
    check("c_m5", 1'b1, 16'h0005);

    // Reset while 4095 sits in stage 1 must discard it
    @(negedge clk);
    tc = 13'd4095;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset", 1'b0, 16'h0000);
    rst = 1'b0;

    apply("c_4095",  4095, 1'b0, 1'b0, 16'h4095);
    apply("c_m4096", -4096, 1'b0, 1'b1, 16'h4096);
    apply("c_0",     0,    1'b0, 1'b0, 16'h0000);
    apply("c_999",   999,  1'b0, 1'b0, 16'h0999);

    apply("f_100",   100,  1'b1, 1'b0, 16'h0212);
    apply("f_m40",   -40,  1'b1, 1'b1, 16'h0040);
    apply("f_4095",  4095, 1'b1, 1'b0, 16'h7403);
    apply("f_m4096", -4096, 1'b1, 1'b1, 16'h7341);
    apply("f_m18",   -18,  1'b1, 1'b0, 16'h0000);
    apply("f_m17",   -17,  1'b1, 1'b0, 16'h0001);
    apply("f_37",    37,   1'b1, 1'b0, 16'h0099);
    apply("f_0",     0,    1'b1, 1'b0, 16'h0032);
    apply("f_m20",   -20,  1'b1, 1'b1, 16'h0004);

    // Back-to-back samples, one per cycle, each seen exactly two edges later
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) check($sformatf("pipe%0d", i - 2), pe_s[i-2], pe_d[i-2]);
      if (i < 3) begin
        tc  = 13'(pv_tc[i]);
        c_f = pv_cf[i];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
